extend16: RTL and testbench
===========================

Name: extend16

Overview:
- Immediate-extension unit for the MIPS datapath.
- Widens a 16-bit instruction immediate to 32 bits using either sign extension or zero extension, selected per instruction by the decoder.
- Provides a combinational result for same-cycle ALU/address use, plus a registered copy with a valid flag for the pipelined datapath.

Parameters:
- OUT_W, 32, output width; legal values ≥ 17; the replicated upper bits are OUT_W-16 wide.
- RESET_VAL, 0, value loaded into out_q on reset.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  16  immediate field.
- zero_sign  input  1  extension mode: 0 = sign extend, 1 = zero extend.
- en  input  1  capture strobe for the registered stage.
- out  output  OUT_W  combinational extended value.
- out_q  output  OUT_W  registered extended value.
- out_valid  output  1  out_q holds a value captured since reset.

Behaviour:
- out is purely combinational from in and zero_sign. No clock or reset dependency, zero latency.
- zero_sign=0: out = {(OUT_W-16){in[15]}, in}.
- zero_sign=1: out = {(OUT_W-16){1'b0}, in}, regardless of in[15].
- out must settle within the same delta/cycle after any change of in or zero_sign, including a mode change with in held constant.
- Registered stage:
  - On rising clk with en=1: out_q <= out (current extended value) and out_valid <= 1.
  - With en=0: out_q and out_valid hold.
  - Latency from in to out_q is one cycle.
- Reset:
  - rst_n low asynchronously forces out_q = RESET_VAL and out_valid = 0, independent of clk.
  - Reset has no effect on out.
  - Release is synchronous to clk: the first capture occurs at the first rising edge with rst_n high and en=1.
- An en edge coincident with rst_n low is ignored; reset wins.
- No X propagation: out is fully determined for all 2^17 input combinations.

Optional Feature:
- Macro: EXTEND16_LUI_EN.
- When defined:
  - Adds input lui (1 bit).
  - lui=1 gives out = {in, (OUT_W-16){1'b0}}, i.e. the immediate is placed in the upper half for the LUI instruction.
  - lui has priority over zero_sign.
  - out_q captures this value the same way as the other modes.
- When undefined:
  - Port lui does not exist.
  - Behaviour is exactly the two-mode sign/zero extension above.

Test Plan:
- in=16'h0fff, zero_sign=0 -> out=32'h00000fff (positive value, sign extend).
- in=16'hf000, zero_sign=0 -> out=32'hfffff000 (negative value, sign extend).
- in=16'hf000, zero_sign=1 -> out=32'h0000f000 (zero extend overrides sign bit).
- Boundaries, zero_sign=0:
  - in=16'h7fff -> out=32'h00007fff.
  - in=16'h8000 -> out=32'hffff8000.
  - in=16'h0000 -> out=32'h00000000.
- Boundary, zero_sign=1: in=16'hffff -> out=32'h0000ffff.
- Registered stage:
  - rst_n=0 mid-run -> out_q=0 and out_valid=0 immediately, without waiting for clk.
  - After release, en=1 with in=16'h8001, zero_sign=0 -> next edge gives out_q=32'hffff8001, out_valid=1.
  - en=0 for 3 cycles while in changes -> out_q holds.
- With EXTEND16_LUI_EN: lui=1, in=16'h1234, zero_sign=0 -> out=32'h12340000.

Source files
------------

// File: rtl/extend16.sv
// Immediate-extension unit: sign/zero extends a 16-bit immediate to OUT_W bits,
// with a registered copy plus valid flag. Define EXTEND16_LUI_EN to add the lui input.
module extend16 #(
  parameter int unsigned      OUT_W     = 32,
  parameter logic [OUT_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      in,
  input  logic             zero_sign,
  input  logic             en,
`ifdef EXTEND16_LUI_EN
  input  logic             lui,
`endif
  output logic [OUT_W-1:0] out,
  output logic [OUT_W-1:0] out_q,
  output logic             out_valid
);

  localparam int unsigned EXT_W = OUT_W - 16;

  logic ext_bit;

  // Zero-extend mode masks the sign bit so the replicated field is all zeros.
  always_comb begin
    ext_bit = in[15] & ~zero_sign;
    out     = {{EXT_W{ext_bit}}, in};
`ifdef EXTEND16_LUI_EN
    if (lui) begin
      out = {in, {EXT_W{1'b0}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= RESET_VAL;
      out_valid <= 1'b0;
    end else if (en) begin
      out_q     <= out;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_extend16.sv
// Self-checking bench for extend16: directed boundary vectors, reset behaviour,
// and randomized stimulus against an arithmetic reference model.
module tb_extend16;

  localparam int unsigned OUT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [15:0]      in = '0;
  logic             zero_sign = 1'b0;
  logic             en = 1'b0;
  logic             lui = 1'b0;
  logic [OUT_W-1:0] out;
  logic [OUT_W-1:0] out_q;
  logic             out_valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] q_exp = '0;
  logic        v_exp = 1'b0;

  extend16 #(.OUT_W(OUT_W), .RESET_VAL(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .zero_sign (zero_sign),
    .en        (en),
`ifdef EXTEND16_LUI_EN
    .lui       (lui),
`endif
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Reference: interpret the immediate numerically, then take the low 32 bits.
  function automatic logic [31:0] ref_ext(logic [15:0] a, logic zs, logic l);
    longint v;
    if (l)
      v = longint'(a) * 65536;
    else if (zs || a < 16'h8000)
      v = longint'(a);
    else
      v = longint'(a) - 65536;
    return v[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply inputs on the falling edge and check the combinational result.
  task automatic drive(input logic [15:0] a, input logic zs, input logic e, input logic l);
    @(negedge clk);
    in = a;
    zero_sign = zs;
    en = e;
    lui = l;
    #1;
    check("comb_out", out, ref_ext(a, zs, l));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n && en) begin
      q_exp = ref_ext(in, zero_sign, lui);
      v_exp = 1'b1;
    end
    #1;
    check("out_q", out_q, q_exp);
    check("out_valid", {31'b0, out_valid}, {31'b0, v_exp});
  endtask

  initial begin
    logic [15:0] dir_in [7];
    logic        dir_zs [7];
    logic [31:0] dir_exp [7];
    dir_in  = '{16'h0fff, 16'hf000, 16'hf000, 16'h7fff, 16'h8000, 16'h0000, 16'hffff};
    dir_zs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    dir_exp = '{32'h00000fff, 32'hfffff000, 32'h0000f000, 32'h00007fff,
                32'hffff8000, 32'h00000000, 32'h0000ffff};

    #1 rst_n = 1'b0;
    #1;
    check("reset_q", out_q, 32'h0);
    check("reset_valid", {31'b0, out_valid}, 32'h0);

    // Directed vectors with fixed expectations while reset is held.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in = dir_in[i];
      zero_sign = dir_zs[i];
      en = 1'b1;
      #1;
      check("dir_out", out, dir_exp[i]);
    end
    // Mode change with in held constant must update out immediately.
    in = 16'h8000;
    zero_sign = 1'b0;
    #1 check("mode_sign", out, 32'hffff8000);
    zero_sign = 1'b1;
    #1 check("mode_zero", out, 32'h00008000);

    // en high across an edge during reset is ignored.
    tick();

    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h8001, 1'b0, 1'b1, 1'b0);
    tick();
    check("first_cap", out_q, 32'hffff8001);

    // Hold for three cycles while in changes.
    for (int i = 0; i < 3; i++) begin
      drive(16'h1111 * 16'(i + 1), 1'(i), 1'b0, 1'b0);
      tick();
      check("hold_q", out_q, 32'hffff8001);
    end

    // Asynchronous reset mid-cycle, no clock edge required.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q_exp = '0;
    v_exp = 1'b0;
    check("async_q", out_q, 32'h0);
    check("async_valid", {31'b0, out_valid}, 32'h0);
    check("reset_no_out", out, ref_ext(in, zero_sign, lui));
    drive(16'h8001, 1'b0, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;

`ifdef EXTEND16_LUI_EN
    drive(16'h1234, 1'b0, 1'b1, 1'b1);
    check("lui_out", out, 32'h12340000);
    tick();
`endif

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a;
      logic        l;
      case ($urandom_range(0, 4))
        0: a = 16'h7fff;
        1: a = 16'h8000;
        default: a = 16'($urandom);
      endcase
      l = 1'b0;
`ifdef EXTEND16_LUI_EN
      l = ($urandom_range(0, 3) == 0);
`endif
      drive(a, 1'($urandom), 1'($urandom), l);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
